tdc_meas_ctrl: RTL and testbench
================================

Name: tdc_meas_ctrl

Overview:
- Measurement sequencer for the carry-chain TDC.
- Gated by a start request, it fires single-cycle hit launches into the chain and waits the fixed capture and decode latency.
- It samples the decoded 8-bit code and accumulates 2^SAMPLE_LOG2 samples into sum, mean, min and max.
- It presents the result on a valid/ready handshake to the downstream consumer (calibration logic or bus register file).

Parameters:
- CODE_W, 8: width of the decoded TDC code.
- SAMPLE_LOG2, 4: log2 of the samples per measurement (16 by default); legal range 0..8.
- LAT, 3: cycles from the hit_o rising cycle to the cycle where code_i is valid; must be >= 1.
- GAP, 2: idle cycles after each capture before the next launch, so the chain can settle; 0 is legal.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  request a new measurement; sampled only in IDLE.
- busy_o  out  1  high from the cycle after start is accepted until the result is accepted.
- hit_o  out  1  launch pulse into the carry-chain CI; exactly one cycle high per sample.
- code_i  in  CODE_W  decoded thermometer-to-binary code from the TDC decoder.
- sum_o  out  CODE_W+SAMPLE_LOG2  sum of accepted samples.
- mean_o  out  CODE_W  sum_o >> SAMPLE_LOG2 (truncating).
- min_o  out  CODE_W  smallest accepted sample.
- max_o  out  CODE_W  largest accepted sample.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  consumer accepts the result.
- rej_cnt_o  out  8  rejected-sample count; present only with the optional feature.

Behaviour:
- Reset (async assert, sync-deasserted use is external):
  - All outputs 0, except min_o = all-ones.
  - State IDLE; all counters 0.
- States: IDLE, LAUNCH, WAIT, CAPTURE, SETTLE, DONE.
- IDLE:
  - On start_i = 1, clear sum, sample counter and max; set min to all-ones.
  - Go to LAUNCH.
  - busy_o goes high the next cycle.
- LAUNCH: hit_o = 1 for this cycle only. Load the wait counter with LAT-1 and go to WAIT.
- WAIT:
  - Decrement the wait counter.
  - On 0, go to CAPTURE, so that CAPTURE is exactly LAT cycles after LAUNCH.
- CAPTURE:
  - Sample code_i.
  - sum += code (zero-extended; never overflows by construction).
  - Update min and max with <= and >= compares.
  - Increment the sample counter.
  - If the counter reaches 2^SAMPLE_LOG2, go to DONE; else go to SETTLE.
- SETTLE:
  - Stay GAP cycles, then go to LAUNCH.
  - With GAP = 0, go directly CAPTURE -> LAUNCH.
  - hit_o is low in all states except LAUNCH.
- DONE:
  - Register the outputs and assert res_valid_o.
  - Outputs hold stable while res_valid_o = 1 and res_ready_i = 0.
  - On valid & ready, drop res_valid_o the next cycle, go to IDLE and drop busy_o.
  - Result registers keep their last value until the next DONE.
- start_i while busy is ignored and not queued.
- start_i in the same cycle as the result handshake is ignored; start is sampled in IDLE only.
- With SAMPLE_LOG2 = 0: one sample, sum = mean = min = max = code.
- Minimum period per sample is 1 + LAT + GAP cycles; total measurement is 2^SAMPLE_LOG2 * (1+LAT+GAP) cycles, plus 1 for DONE entry.
- Deasserting rst_n mid-measurement aborts immediately: hit_o low and all outputs to reset values.

Optional Feature:
- Macro: TDC_REJECT_EN.
- Defined:
  - In CAPTURE, a code of 0 (hit not propagated) or all-ones (chain overflow) is rejected: no accumulate, no sample-counter increment.
  - The rejected-sample count increments, saturating at 255, and the sequencer goes to SETTLE and relaunches.
  - rej_cnt_o is the registered count of the current/last measurement, cleared on start.
  - After 255 rejections, DONE is forced with the partial result, and sum is not rescaled.
- Undefined: all codes are accepted, and the rej_cnt_o port and its logic are absent.

Decomposition:
- Package tdc_pkg:
  - State enum type tdc_meas_state_t.
  - CODE_W default constant.
  - Code constants CODE_MIN = 0 and CODE_MAX = all-ones.
- Sub-module tdc_stat_acc: sum/min/max accumulator with clear and accumulate enables.
  - It is reusable by later calibration blocks.
- The FSM and counters live in the top module.

Test Plan:
- Constant code: code_i = 0x40, default params, pulse start -> hit_o pulses exactly 16 times, each 6 cycles apart; CAPTURE is 3 cycles after each pulse; result sum = 0x400, mean = 0x40, min = max = 0x40.
- Ramp: code increments 10, 11, ..., 25 per capture -> sum = 280, mean = 17, min = 10, max = 25.
- Backpressure: hold res_ready_i = 0 for 20 cycles after valid -> outputs stable and no hit_o pulses; on ready, valid drops the next cycle and busy_o drops.
- start_i pulsed mid-measurement and again on the handshake cycle -> no extra launches; only one result.
- rst_n low during WAIT of sample 5 -> outputs go to reset immediately; a new start afterwards yields a full 16-sample result.
- TDC_REJECT_EN: code alternates 0 and 0x20 -> 32 launches in total, rej_cnt_o = 16, sum = 0x200.

Source files
------------

// File: rtl/tdc_meas_ctrl_pkg.sv
// Shared types and constants for the carry-chain TDC measurement sequencer.
package tdc_pkg;

    localparam int CODE_W = 8;

    localparam logic [CODE_W-1:0] CODE_MIN = '0;
    localparam logic [CODE_W-1:0] CODE_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_CAPTURE,
        ST_SETTLE,
        ST_DONE
    } tdc_meas_state_t;

endpackage

// File: rtl/tdc_meas_ctrl_if.sv
// Result handshake between the TDC sequencer (master) and its consumer (slave).
// rej_cnt_o exists only when TDC_REJECT_EN is defined.
interface tdc_meas_ctrl_if #(
    parameter int CODE_W      = 8,
    parameter int SAMPLE_LOG2 = 4
);
    logic [CODE_W+SAMPLE_LOG2-1:0] sum_o;
    logic [CODE_W-1:0]             mean_o;
    logic [CODE_W-1:0]             min_o;
    logic [CODE_W-1:0]             max_o;
    logic                          res_valid_o;
    logic                          res_ready_i;
`ifdef TDC_REJECT_EN
    logic [7:0]                    rej_cnt_o;

    modport master (output sum_o, mean_o, min_o, max_o, res_valid_o, rej_cnt_o,
                    input  res_ready_i);
    modport slave  (input  sum_o, mean_o, min_o, max_o, res_valid_o, rej_cnt_o,
                    output res_ready_i);
`else
    modport master (output sum_o, mean_o, min_o, max_o, res_valid_o,
                    input  res_ready_i);
    modport slave  (input  sum_o, mean_o, min_o, max_o, res_valid_o,
                    output res_ready_i);
`endif
endinterface

// File: rtl/tdc_stat_acc.sv
// Running sum/min/max of a code stream; clear wins over accumulate.
module tdc_stat_acc #(
    parameter int CODE_W = 8,
    parameter int SUM_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              acc_i,
    input  logic [CODE_W-1:0] code_i,
    output logic [SUM_W-1:0]  sum_o,
    output logic [CODE_W-1:0] min_o,
    output logic [CODE_W-1:0] max_o
);
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [CODE_W-1:0] min_q, min_d;
    logic [CODE_W-1:0] max_q, max_d;

    always_comb begin
        // NOTE: every next-state gets a default first so no path infers a latch.
        sum_d = sum_q;
        min_d = min_q;
        max_d = max_q;
        if (clr_i) begin
            sum_d = '0;
            min_d = '1;
            max_d = '0;
        end else if (acc_i) begin
            sum_d = sum_q + SUM_W'(code_i);
            if (code_i <= min_q) min_d = code_i;
            if (code_i >= max_q) max_d = code_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking so every register samples pre-edge values.
        if (!rst_n) begin
            sum_q <= '0;
            min_q <= '1;
            max_q <= '0;
        end else begin
            sum_q <= sum_d;
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign sum_o = sum_q;
    assign min_o = min_q;
    assign max_o = max_q;

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Carry-chain TDC measurement sequencer: launch, wait LAT, capture, settle GAP, repeat
// 2^SAMPLE_LOG2 times, then present sum/mean/min/max. Optional TDC_REJECT_EN rejects 0/all-ones codes.
module tdc_meas_ctrl #(
    parameter int CODE_W      = 8,
    parameter int SAMPLE_LOG2 = 4,
    parameter int LAT         = 3,
    parameter int GAP         = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic              busy_o,
    output logic              hit_o,
    input  logic [CODE_W-1:0] code_i,
    tdc_meas_ctrl_if.master   res_if
);
    import tdc_pkg::*;

    localparam int SUM_W   = CODE_W + SAMPLE_LOG2;
    localparam int SAMP_W  = SAMPLE_LOG2 + 1;
    localparam int CNT_MAX = (LAT > GAP) ? LAT : ((GAP > 1) ? GAP : 1);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [SAMP_W-1:0] LAST_SAMP = SAMP_W'((1 << SAMPLE_LOG2) - 1);

    tdc_meas_state_t   state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [SAMP_W-1:0] samp_q;
    logic              hit_q, busy_q, valid_q;
    logic [SUM_W-1:0]  sum_q;
    logic [CODE_W-1:0] mean_q, min_q, max_q;

    logic              acc_clr, acc_en, code_rej, cap_done;
    logic [SUM_W-1:0]  acc_sum;
    logic [CODE_W-1:0] acc_min, acc_max;

`ifdef TDC_REJECT_EN
    logic [7:0] rej_q;
    assign code_rej = (code_i == '0) || (code_i == '1);
    // The 255th rejection forces DONE with whatever was accumulated so far.
    assign cap_done = code_rej ? (rej_q >= 8'd254) : (samp_q == LAST_SAMP);
    assign res_if.rej_cnt_o = rej_q;
`else
    assign code_rej = 1'b0;
    assign cap_done = (samp_q == LAST_SAMP);
`endif

    assign acc_clr = (state_q == ST_IDLE) && start_i;
    assign acc_en  = (state_q == ST_CAPTURE) && !code_rej;

    tdc_stat_acc #(.CODE_W(CODE_W), .SUM_W(SUM_W)) u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (acc_clr),
        .acc_i  (acc_en),
        .code_i (code_i),
        .sum_o  (acc_sum),
        .min_o  (acc_min),
        .max_o  (acc_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            samp_q  <= '0;
            hit_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            sum_q   <= '0;
            mean_q  <= '0;
            min_q   <= '1;
            max_q   <= '0;
`ifdef TDC_REJECT_EN
            rej_q   <= '0;
`endif
        end else begin
            // hit_q is raised only on the edge entering LAUNCH, so it is high for LAUNCH alone.
            hit_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (start_i) begin
                    samp_q  <= '0;
                    busy_q  <= 1'b1;
                    hit_q   <= 1'b1;
                    state_q <= ST_LAUNCH;
`ifdef TDC_REJECT_EN
                    rej_q   <= '0;
`endif
                end
                ST_LAUNCH: begin
                    if (LAT == 1) begin
                        state_q <= ST_CAPTURE;
                    end else begin
                        cnt_q   <= CNT_W'(LAT - 1);
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == CNT_W'(1)) state_q <= ST_CAPTURE;
                    else                    cnt_q   <= cnt_q - CNT_W'(1);
                end
                ST_CAPTURE: begin
                    if (!code_rej) samp_q <= samp_q + SAMP_W'(1);
`ifdef TDC_REJECT_EN
                    if (code_rej && (rej_q != 8'hFF)) rej_q <= rej_q + 8'd1;
`endif
                    if (cap_done) begin
                        state_q <= ST_DONE;
                    end else if (GAP == 0) begin
                        hit_q   <= 1'b1;
                        state_q <= ST_LAUNCH;
                    end else begin
                        cnt_q   <= CNT_W'(GAP);
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == CNT_W'(1)) begin
                        hit_q   <= 1'b1;
                        state_q <= ST_LAUNCH;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (!valid_q) begin
                        sum_q   <= acc_sum;
                        mean_q  <= acc_sum[SUM_W-1:SAMPLE_LOG2];
                        min_q   <= acc_min;
                        max_q   <= acc_max;
                        valid_q <= 1'b1;
                    end else if (res_if.res_ready_i) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o             = busy_q;
    assign hit_o              = hit_q;
    assign res_if.sum_o       = sum_q;
    assign res_if.mean_o      = mean_q;
    assign res_if.min_o       = min_q;
    assign res_if.max_o       = max_q;
    assign res_if.res_valid_o = valid_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed bench for tdc_meas_ctrl with a result scoreboard; the reject scenario
// runs only when TDC_REJECT_EN is defined.
module tb_tdc_meas_ctrl;
    import tdc_pkg::*;

    localparam int PERIOD = 6;   // 1 + LAT + GAP with default parameters
    localparam logic [7:0] JUNK = 8'hEE;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic       busy_o, hit_o;
    logic [7:0] code_i = 8'h00;

    tdc_meas_ctrl_if res_if ();

    tdc_meas_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .busy_o  (busy_o),
        .hit_o   (hit_o),
        .code_i  (code_i),
        .res_if  (res_if.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] sum;
        logic [7:0]  mean;
        logic [7:0]  min;
        logic [7:0]  max;
        logic [7:0]  rej;
        int          hits;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // mode 0: constant 0x40, 1: ramp 10+k, 2: alternating 0 / 0x20
    function automatic logic [7:0] code_for(input int mode, input int k);
        case (mode)
            0:       return 8'h40;
            1:       return 8'(10 + k);
            default: return ((k % 2) == 1) ? 8'h20 : CODE_MIN;
        endcase
    endfunction

    function automatic exp_t model(input int mode);
        exp_t e;
        logic [7:0] c;
        int acc = 0;
        e.sum = '0; e.min = CODE_MAX; e.max = CODE_MIN; e.rej = '0;
        e.hits = (mode == 2) ? 32 : 16;
        for (int k = 0; k < e.hits; k++) begin
            c = code_for(mode, k);
            if (mode == 2 && (c == CODE_MIN || c == CODE_MAX)) begin
                e.rej = e.rej + 8'd1;
            end else begin
                e.sum = e.sum + 12'(c);
                if (c < e.min) e.min = c;
                if (c > e.max) e.max = c;
                acc++;
            end
        end
        e.mean = 8'(e.sum >> 4);
        return e;
    endfunction

    task automatic run_meas(input int mode, input bit poke, output exp_t e);
        int   hits = 0;
        int   last = -100;
        int   cap_cyc = -100;
        logic [7:0] cap_val = 8'h00;
        bit   got = 1'b0;
        sb.push_back(model(mode));
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("busy_after_start", busy_o, 1'b1);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (res_if.res_valid_o) begin
                got = 1'b1;
                break;
            end
            if (hit_o) begin
                if (hits == 0) check("first_hit_cycle", cyc, 0);
                else           check("hit_spacing", cyc - last, PERIOD);
                last    = cyc;
                cap_cyc = cyc + 3;
                cap_val = code_for(mode, hits);
                hits++;
            end
            // The code is only correct during the capture cycle; junk surrounds it.
            if (cyc == cap_cyc)          code_i = cap_val;
            else if (cyc == cap_cyc + 1) code_i = JUNK;
            start_i = poke && (hits == 5) && (cyc == last + 1);
            @(negedge clk);
        end
        start_i = 1'b0;
        check("valid_seen", got, 1'b1);
        e = sb.pop_front();
        check("hit_count", hits, e.hits);
        check("busy_at_valid", busy_o, 1'b1);
        check("sum", res_if.sum_o, e.sum);
        check("mean", res_if.mean_o, e.mean);
        check("min", res_if.min_o, e.min);
        check("max", res_if.max_o, e.max);
`ifdef TDC_REJECT_EN
        check("rej_cnt", res_if.rej_cnt_o, e.rej);
`endif
    endtask

    task automatic handshake(input exp_t e, input int hold, input bit poke);
        int bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (hit_o) bad++;
            check("hold_valid", res_if.res_valid_o, 1'b1);
            check("hold_sum", res_if.sum_o, e.sum);
        end
        check("hold_no_hits", bad, 0);
        check("hold_min", res_if.min_o, e.min);
        check("hold_max", res_if.max_o, e.max);
        res_if.res_ready_i = 1'b1;
        start_i = poke;
        @(negedge clk);
        res_if.res_ready_i = 1'b0;
        start_i = 1'b0;
        check("valid_drop", res_if.res_valid_o, 1'b0);
        check("busy_drop", busy_o, 1'b0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (hit_o || busy_o || res_if.res_valid_o) bad++;
        end
        check("idle_after_hs", bad, 0);
        check("sum_kept", res_if.sum_o, e.sum);
        check("mean_kept", res_if.mean_o, e.mean);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hit"}, hit_o, 1'b0);
        check({tag, "_busy"}, busy_o, 1'b0);
        check({tag, "_valid"}, res_if.res_valid_o, 1'b0);
        check({tag, "_sum"}, res_if.sum_o, 12'h000);
        check({tag, "_mean"}, res_if.mean_o, 8'h00);
        check({tag, "_min"}, res_if.min_o, CODE_MAX);
        check({tag, "_max"}, res_if.max_o, 8'h00);
    endtask

    task automatic abort_in_wait();
        int  hits = 0;
        bit  got = 1'b0;
        code_i = 8'h40;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (hit_o) hits++;
            if (hits == 5) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("abort_reached_5th", got, 1'b1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_abort");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   bad;
        res_if.res_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (hit_o || busy_o) bad++;
        end
        check("idle_without_start", bad, 0);

        run_meas(0, 1'b0, e);
        handshake(e, 0, 1'b0);

        run_meas(1, 1'b1, e);
        handshake(e, 20, 1'b1);

        abort_in_wait();

        run_meas(1, 1'b0, e);
        handshake(e, 0, 1'b0);

`ifdef TDC_REJECT_EN
        run_meas(2, 1'b0, e);
        handshake(e, 0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
